// File: rtl/gpio_serial_pkg.sv
// Shared definitions for the gpio serial chain loader: FSM state encoding
// and the default per-pad configuration width.
package gpio_serial_pkg;

   localparam int PAD_CTRL_BITS_DEF = 10;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT_LO,
      SHIFT_HI,
      LOAD,
      DONE
   } state_t;

endpackage

// File: rtl/gpio_serial_tick.sv
// Phase timer: pulses tick on the last cycle of every HALF_PERIOD-cycle
// window; restart realigns the window so the next cycle is its first.
module gpio_serial_tick #(
   parameter int HALF_PERIOD = 2
) (
   input  logic clk,
   input  logic srst,
   input  logic restart,
   output logic tick
);

   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (srst || restart || (cnt_reg == LAST)) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/gpio_serial_loader.sv
// Serialises NUM_GPIO configuration words onto the gpio control chain,
// highest index first, MSB first, then strobes serial_load.
module gpio_serial_loader
   import gpio_serial_pkg::*;
#(
   parameter int NUM_GPIO      = 19,
   parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DEF,
   parameter int HALF_PERIOD   = 2,
   localparam int AW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     xfer_start,
   output logic [AW-1:0]            cfg_addr,
   input  logic [PAD_CTRL_BITS-1:0] cfg_data,
   output logic                     serial_clock,
   output logic                     serial_data,
   output logic                     serial_load,
   output logic                     serial_resetn,
   output logic                     busy,
   output logic                     xfer_done
);

   localparam int BW = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(PAD_CTRL_BITS - 1);
   localparam logic [AW-1:0] TOP_ADDR = AW'(NUM_GPIO - 1);

   state_t                   state_reg;
   logic [PAD_CTRL_BITS-1:0] word_reg;
   logic [BW-1:0]            bit_cnt_reg;
   logic                     tick;

   // FETCH is exactly one cycle, so restarting there aligns the first
   // SHIFT_LO window; later windows chain off the free-running wrap.
   gpio_serial_tick #(
      .HALF_PERIOD(HALF_PERIOD)
   ) u_tick (
      .clk    (wb_clk_i),
      .srst   (wb_rst_i),
      .restart(state_reg == FETCH),
      .tick   (tick)
   );

   always_ff @(posedge wb_clk_i) begin
      serial_resetn <= ~wb_rst_i;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg    <= IDLE;
         word_reg     <= '0;
         bit_cnt_reg  <= '0;
         cfg_addr     <= '0;
         serial_clock <= 1'b0;
         serial_data  <= 1'b0;
         serial_load  <= 1'b0;
         busy         <= 1'b0;
         xfer_done    <= 1'b0;
      end else begin
         xfer_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (xfer_start) begin
                  state_reg <= FETCH;
                  cfg_addr  <= TOP_ADDR;
                  busy      <= 1'b1;
               end
            end
            FETCH: begin
               // MSB goes straight to the pin; word_reg keeps the remaining bits.
               serial_data <= cfg_data[PAD_CTRL_BITS-1];
               word_reg    <= cfg_data << 1;
               bit_cnt_reg <= '0;
               state_reg   <= SHIFT_LO;
            end
            SHIFT_LO: begin
               if (tick) begin
                  serial_clock <= 1'b1;
                  state_reg    <= SHIFT_HI;
               end
            end
            SHIFT_HI: begin
               if (tick) begin
                  serial_clock <= 1'b0;
                  word_reg     <= word_reg << 1;
                  bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == LAST_BIT) begin
                     bit_cnt_reg <= '0;
                     if (cfg_addr != '0) begin
                        cfg_addr  <= cfg_addr - 1'b1;
                        state_reg <= FETCH;
                     end else begin
                        serial_data <= 1'b0;
                        serial_load <= 1'b1;
                        state_reg   <= LOAD;
                     end
                  end else begin
                     serial_data <= word_reg[PAD_CTRL_BITS-1];
                     state_reg   <= SHIFT_LO;
                  end
               end
            end
            LOAD: begin
               if (tick) begin
                  serial_load <= 1'b0;
                  xfer_done   <= 1'b1;
                  state_reg   <= DONE;
               end
            end
            DONE: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   a_data_stable: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
      serial_clock |-> $stable(serial_data));
   a_load_clock: assert property (@(posedge wb_clk_i)
      !(serial_load && serial_clock));
   a_busy_state: assert property (@(posedge wb_clk_i)
      busy == (state_reg != IDLE));

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Randomised and directed checks of the chain loader against a shift-chain
// reference model, on a 2-word/HP1 and a 1-word/HP3 configuration.
module tb_gpio_serial_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b;
   logic [0:0] addr_a, addr_b;
   logic [9:0] cfg_a [2];
   logic [9:0] cfg_b [1];
   logic       sclk_a, sdata_a, sload_a, rstn_a, busy_a, done_a;
   logic       sclk_b, sdata_b, sload_b, rstn_b, busy_b, done_b;
   logic [9:0] cfg_data_a, cfg_data_b;

   int sel;
   logic m_sclk, m_sdata, m_sload, m_rstn, m_busy, m_done;
   logic [0:0] m_addr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign cfg_data_a = cfg_a[addr_a];
   assign cfg_data_b = cfg_b[0];

   gpio_serial_loader #(.NUM_GPIO(2), .PAD_CTRL_BITS(10), .HALF_PERIOD(1)) u_dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start_a), .cfg_addr(addr_a),
      .cfg_data(cfg_data_a), .serial_clock(sclk_a), .serial_data(sdata_a),
      .serial_load(sload_a), .serial_resetn(rstn_a), .busy(busy_a), .xfer_done(done_a));

   gpio_serial_loader #(.NUM_GPIO(1), .PAD_CTRL_BITS(10), .HALF_PERIOD(3)) u_dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start_b), .cfg_addr(addr_b),
      .cfg_data(cfg_data_b), .serial_clock(sclk_b), .serial_data(sdata_b),
      .serial_load(sload_b), .serial_resetn(rstn_b), .busy(busy_b), .xfer_done(done_b));

   always_comb begin
      m_sclk  = sclk_a;  m_sdata = sdata_a; m_sload = sload_a;
      m_rstn  = rstn_a;  m_busy  = busy_a;  m_done  = done_a;  m_addr = addr_a;
      if (sel != 0) begin
         m_sclk  = sclk_b;  m_sdata = sdata_b; m_sload = sload_b;
         m_rstn  = rstn_b;  m_busy  = busy_b;  m_done  = done_b;  m_addr = addr_b;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_sclk"}, m_sclk, 0);
      check({tag, "_sdata"}, m_sdata, 0);
      check({tag, "_sload"}, m_sload, 0);
      check({tag, "_busy"}, m_busy, 0);
      check({tag, "_done"}, m_done, 0);
      check({tag, "_addr"}, m_addr, 0);
   endtask

   // One transfer on instance s; optional re-start pulse and reset abort at given cycles.
   task automatic run_xfer(input int s, input int restart_at, input int abort_at);
      int n, hp, exp_len, cyc, load_cycles, done_cnt, done_cyc, bit_idx;
      bit exp_bits[$];
      logic [31:0] chain, latched;
      logic prev_clk, prev_data, prev_load;
      sel = s;
      n  = (s != 0) ? 1 : 2;
      hp = (s != 0) ? 3 : 1;
      exp_len = n * (1 + 2 * hp * 10) + hp + 1;
      for (int w = n - 1; w >= 0; w--)
         for (int b = 9; b >= 0; b--)
            exp_bits.push_back((s != 0) ? cfg_b[0][b] : cfg_a[w][b]);
      check_idle("pre_idle");
      @(negedge clk);
      if (s != 0) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      check("busy_start", m_busy, 1);
      check("addr_start", m_addr, n - 1);
      cyc = 1; load_cycles = 0; done_cnt = 0; done_cyc = 0; bit_idx = 0;
      chain = '0; latched = '0;
      prev_clk = m_sclk; prev_data = m_sdata; prev_load = m_sload;
      while (cyc < exp_len + 20 && done_cnt == 0) begin
         @(negedge clk);
         cyc++;
         start_a = 1'b0; start_b = 1'b0;
         if (cyc == restart_at) begin
            if (s != 0) start_b = 1'b1; else start_a = 1'b1;
         end
         if (cyc == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            check_idle("abort");
            check("abort_rstn", m_rstn, 0);
            check("abort_no_load", load_cycles, 0);
            rst = 1'b0;
            @(negedge clk);
            check("abort_rstn_rel", m_rstn, 1);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("abort_no_done", m_done | m_sload, 0);
            end
            $display("[TB] xfer sel=%0d aborted at cycle %0d", s, cyc);
            return;
         end
         check("clk_load_excl", m_sclk & m_sload, 0);
         if (m_sclk) check("data_hi_stable", m_sdata, prev_data);
         if (m_sclk && !prev_clk) begin
            if (bit_idx < exp_bits.size()) check("bit", m_sdata, exp_bits[bit_idx]);
            bit_idx++;
            chain = {chain[30:0], m_sdata};
         end
         if (m_sload) begin
            load_cycles++;
            if (!prev_load) latched = chain;
         end
         if (m_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_clk = m_sclk; prev_data = m_sdata; prev_load = m_sload;
      end
      check("xfer_len", done_cyc, exp_len);
      check("bit_count", bit_idx, n * 10);
      check("load_cycles", load_cycles, hp);
      for (int k = 0; k < n; k++)
         check("chain_block", latched[k*10 +: 10], (s != 0) ? cfg_b[0] : cfg_a[k]);
      @(negedge clk);
      check_idle("post_idle");
      $display("[TB] xfer sel=%0d len=%0d bits=%0d load=%0d block0=%03h", s, done_cyc, bit_idx,
               load_cycles, latched[9:0]);
   endtask

   initial begin
      sel = 0;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      cfg_a[0] = 10'h15A; cfg_a[1] = 10'h2A5; cfg_b[0] = 10'h3FF;
      repeat (3) @(negedge clk);
      check("rst_rstn_a", rstn_a, 0);
      check("rst_rstn_b", rstn_b, 0);
      check_idle("rst_a");
      rst = 1'b0;
      @(negedge clk);
      check("rstn_rel_a", rstn_a, 1);
      check("rstn_rel_b", rstn_b, 1);

      run_xfer(0, 0, 0);
      run_xfer(1, 0, 0);
      run_xfer(0, 10, 0);
      run_xfer(0, 0, 20);
      run_xfer(0, 0, 0);
      for (int r = 0; r < 4; r++) begin
         cfg_a[0] = 10'($urandom); cfg_a[1] = 10'($urandom); cfg_b[0] = 10'($urandom);
         run_xfer(r % 2, 0, 0);
      end
      cfg_b[0] = 10'($urandom);
      run_xfer(1, 0, 30);
      run_xfer(1, 7, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_serial_loader.md
GPIO_SERIAL_LOADER -- requirements
Module: gpio_serial_loader

Interface
REQ-001: Parameter NUM_GPIO, default 19, is the number of gpio control blocks on the driven chain.
REQ-002: Parameter PAD_CTRL_BITS, default 10, is the configuration bits per gpio block.
REQ-003: Parameter HALF_PERIOD, default 2, is the wb_clk_i cycles per serial_clock phase (>=1).
REQ-004: wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-005: wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006: xfer_start  input  1  one-cycle pulse requesting a full chain load.
REQ-007: cfg_addr  output  $clog2(NUM_GPIO)  registered index of the gpio word being fetched.
REQ-008: cfg_data  input  PAD_CTRL_BITS  configuration word for cfg_addr, combinational from the register bank.
REQ-009: serial_clock  output  1  chain shift clock.
REQ-010: serial_data  output  1  chain serial data.
REQ-011: serial_load  output  1  chain load strobe.
REQ-012: serial_resetn  output  1  chain reset, active-low.
REQ-013: busy  output  1  high while a transfer is in progress.
REQ-014: xfer_done  output  1  one-cycle pulse at transfer end.

Function
REQ-015: FSM states SHALL be IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
REQ-016: IDLE: xfer_start=1 -> FETCH, with cfg_addr=NUM_GPIO-1 and busy=1 from the next cycle; xfer_start while busy SHALL be ignored.
REQ-017: FETCH: one cycle; SHALL capture cfg_data into a PAD_CTRL_BITS shift register, reset bit counter, -> SHIFT_LO.
REQ-018: SHIFT_LO: serial_clock=0, serial_data=current word MSB, held HALF_PERIOD cycles, -> SHIFT_HI.
REQ-019: SHIFT_HI: serial_clock=1, serial_data unchanged, held HALF_PERIOD cycles; on exit, word shifts left one bit and bit counter increments.
REQ-020: Bits SHALL be sent MSB (bit PAD_CTRL_BITS-1) first; words sent from index NUM_GPIO-1 down to 0, so word k lands in chain block k.
REQ-021: After the last bit of a word: cfg_addr!=0 -> decrement cfg_addr, -> FETCH; cfg_addr==0 -> LOAD.
REQ-022: LOAD: serial_clock=0, serial_load=1 for HALF_PERIOD cycles, -> DONE.
REQ-023: DONE: serial_load=0, xfer_done=1 for one cycle, busy=0 on the next cycle, -> IDLE.
REQ-024: Transfer length SHALL be exactly NUM_GPIO*(1+2*HALF_PERIOD*PAD_CTRL_BITS)+HALF_PERIOD+1 cycles from first FETCH to DONE inclusive.
REQ-025: serial_data SHALL change only when serial_clock is low; no change in the cycle serial_clock rises.
REQ-026: serial_load and serial_clock SHALL never be high in the same cycle.
REQ-027: All outputs SHALL be registered (glitch-free).
REQ-028: In IDLE: serial_clock=0, serial_load=0, serial_data=0, cfg_addr=0.

Reset
REQ-029: wb_rst_i=1 SHALL force, on the next edge, state=IDLE, serial_clock=0, serial_data=0, serial_load=0, busy=0, xfer_done=0, cfg_addr=0, all counters 0, from any state including mid-transfer.
REQ-030: serial_resetn SHALL be 0 during reset and go 1 one cycle after wb_rst_i deasserts.
REQ-031: An aborted transfer SHALL NOT pulse serial_load or xfer_done.

Structure
REQ-032: State encoding and the PAD_CTRL_BITS default constant SHALL live in shared package gpio_serial_pkg.
REQ-033: Phase timing SHALL be one sub-module, gpio_serial_tick: counter emitting a one-cycle tick every HALF_PERIOD cycles, restartable by the FSM.

Verification
REQ-034: NUM_GPIO=2, HALF_PERIOD=1, cfg[1]=10'h2A5, cfg[0]=10'h15A, pulse xfer_start -> bit stream 1010100101 then 0101011010; serial_load high 1 cycle; xfer_done at cycle 44.
REQ-035: Same config, chain model of 2 gpio blocks -> after serial_load, block1 holds 10'h2A5, block0 holds 10'h15A.
REQ-036: xfer_start re-pulsed at cycle 10 of a transfer -> ignored; exactly one xfer_done; total length unchanged.
REQ-037: wb_rst_i asserted at cycle 20 of a transfer -> next cycle all outputs at reset values, serial_load never asserted, serial_resetn=0.
REQ-038: HALF_PERIOD=3, NUM_GPIO=1, cfg[0]=10'h3FF -> serial_clock high 3 / low 3 cycles, serial_data=1 across 10 bits, xfer_done at cycle 65.
REQ-039: Assertions throughout: serial_data stable while serial_clock high; never serial_load&serial_clock; busy==(state!=IDLE).
